// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one register read/write per command, MDC = clk_i / (2*CLK_DIV).
// Build option MDIO_PRE_SUPPRESS_EN adds cmd_no_pre_i to skip the preamble on a per-command basis.
module mdio_master #(
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [4:0]  cmd_phy_addr_i,
  input  logic [4:0]  cmd_reg_addr_i,
  input  logic [15:0] cmd_wdata_i,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        cmd_no_pre_i,
`endif
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam int unsigned CW       = $clog2(CLK_DIV);
  localparam int unsigned BIT_LAST = PRE_LEN + 32;
  localparam int unsigned BW       = $clog2(BIT_LAST + 1);
  localparam int unsigned IDX_ST   = PRE_LEN;
  localparam int unsigned IDX_OP   = PRE_LEN + 2;
  localparam int unsigned IDX_PHY  = PRE_LEN + 4;
  localparam int unsigned IDX_REG  = PRE_LEN + 9;
  localparam int unsigned IDX_TA   = PRE_LEN + 14;
  localparam int unsigned IDX_DATA = PRE_LEN + 16;
  localparam int unsigned IDX_IDLE = PRE_LEN + 32;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_IDLE_BIT, S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   div_q;
  logic [BW-1:0]   bit_q;
  logic [31:0]     frame_q;
  logic            write_q;
  logic [31:0]     new_frame_c;
  logic [BW-1:0]   start_idx_c;
  logic [BW-1:0]   bit_nxt_c;
  logic            accept_c;

  // ST, OP, PHYAD, REGAD, TA, DATA packed MSB first; read TA/DATA slots are never driven.
  function automatic logic [31:0] build_frame(input logic wr, input logic [4:0] phy,
                                              input logic [4:0] rg, input logic [15:0] wd);
    return {2'b01, wr ? 2'b01 : 2'b10, phy, rg, wr ? 2'b10 : 2'b11, wr ? wd : 16'hFFFF};
  endfunction

  function automatic state_t phase_of(input logic [BW-1:0] idx);
    if (idx < BW'(IDX_ST))        return S_PRE;
    else if (idx < BW'(IDX_OP))   return S_ST;
    else if (idx < BW'(IDX_PHY))  return S_OP;
    else if (idx < BW'(IDX_REG))  return S_PHYAD;
    else if (idx < BW'(IDX_TA))   return S_REGAD;
    else if (idx < BW'(IDX_DATA)) return S_TA;
    else if (idx < BW'(IDX_IDLE)) return S_DATA;
    else                          return S_IDLE_BIT;
  endfunction

  // Returns {mdio, oe} for bit index idx; the bus idles high when released.
  function automatic logic [1:0] drive_of(input logic [BW-1:0] idx, input logic [31:0] frame,
                                          input logic wr);
    logic [4:0] off;
    off = 5'(BW'(BIT_LAST - 1) - idx);
    if (idx < BW'(IDX_ST))              return 2'b11;
    else if (idx >= BW'(IDX_IDLE))      return 2'b10;
    else if (!wr && idx >= BW'(IDX_TA)) return 2'b10;
    else                                return {frame[off], 1'b1};
  endfunction

  assign accept_c    = cmd_valid_i & cmd_ready_o;
  assign new_frame_c = build_frame(cmd_write_i, cmd_phy_addr_i, cmd_reg_addr_i, cmd_wdata_i);
  assign bit_nxt_c   = bit_q + 1'b1;

`ifdef MDIO_PRE_SUPPRESS_EN
  // Skipping the preamble just starts the bit counter at ST.
  assign start_idx_c = cmd_no_pre_i ? BW'(PRE_LEN) : '0;
`else
  assign start_idx_c = '0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= S_IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mdc_o       <= 1'b0;
      mdio_o      <= 1'b1;
      mdio_oe_o   <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      write_q     <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            frame_q                <= new_frame_c;
            write_q                <= cmd_write_i;
            bit_q                  <= start_idx_c;
            div_q                  <= '0;
            mdc_o                  <= 1'b0;
            {mdio_o, mdio_oe_o}    <= drive_of(start_idx_c, new_frame_c, cmd_write_i);
            state                  <= phase_of(start_idx_c);
            cmd_ready_o            <= 1'b0;
            busy_o                 <= 1'b1;
            rsp_rdata_o            <= '0;
            rsp_err_o              <= 1'b0;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          cmd_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          if (div_q == CW'(CLK_DIV - 1)) begin
            div_q <= '0;
            mdc_o <= ~mdc_o;
            if (!mdc_o) begin
              // MDC rising: sample the PHY-driven TA and data bits.
              if (!write_q && bit_q == BW'(IDX_TA + 1) && mdio_i) rsp_err_o <= 1'b1;
              if (!write_q && state == S_DATA) rsp_rdata_o <= {rsp_rdata_o[14:0], mdio_i};
            end else if (bit_q == BW'(BIT_LAST)) begin
              state       <= S_DONE;
              rsp_valid_o <= 1'b1;
              mdio_o      <= 1'b1;
              mdio_oe_o   <= 1'b0;
            end else begin
              bit_q               <= bit_nxt_c;
              {mdio_o, mdio_oe_o} <= drive_of(bit_nxt_c, frame_q, write_q);
              state               <= phase_of(bit_nxt_c);
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master (CLK_DIV=4, PRE_LEN=32) with a simple PHY model on MDIO.
// Preamble-suppression frames are exercised only when MDIO_PRE_SUPPRESS_EN is defined.
module tb_mdio_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned PRE_LEN = 32;

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wdata;
    logic        drive;
    logic [15:0] pdata;
    logic [31:0] exp_frame;
    logic [31:0] exp_oe;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [4:0]  cmd_phy_addr_i;
  logic [4:0]  cmd_reg_addr_i;
  logic [15:0] cmd_wdata_i;
  logic        no_pre;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        mdc_o;
  logic        mdio_o;
  logic        mdio_oe_o;
  logic        mdio_i = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  logic        cap_d[$];
  logic        cap_oe[$];
  int          cap_base;
  int          rise_total = 0;
  int          rise_base  = 0;
  logic        phy_drive  = 1'b0;
  logic [15:0] phy_data   = 16'h0000;

  vec_t vecs[5];

  mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_write_i    (cmd_write_i),
    .cmd_phy_addr_i (cmd_phy_addr_i),
    .cmd_reg_addr_i (cmd_reg_addr_i),
    .cmd_wdata_i    (cmd_wdata_i),
`ifdef MDIO_PRE_SUPPRESS_EN
    .cmd_no_pre_i   (no_pre),
`endif
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o),
    .mdc_o          (mdc_o),
    .mdio_o         (mdio_o),
    .mdio_oe_o      (mdio_oe_o),
    .mdio_i         (mdio_i)
  );

  always #5 clk_i = ~clk_i;

  // PHY model: drives TA2=0 and the read data, otherwise the pull-up leaves the line at 1.
  function automatic logic model_bit(input int k);
    if (!phy_drive) return 1'b1;
    if (k == int'(PRE_LEN) + 15) return 1'b0;
    if (k >= int'(PRE_LEN) + 16 && k < int'(PRE_LEN) + 32) return phy_data[int'(PRE_LEN) + 31 - k];
    return 1'b1;
  endfunction

  always @(posedge mdc_o) begin
    cap_d.push_back(mdio_o);
    cap_oe.push_back(mdio_oe_o);
    rise_total = rise_total + 1;
    #1 mdio_i = model_bit(rise_total - rise_base);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!cmd_ready_o && guard < 3000) begin
      @(posedge clk_i); #1;
      guard++;
    end
  endtask

  // Issues one command and returns the number of clk_i edges from accept to rsp_valid_o.
  task automatic do_txn(input vec_t v, input logic np, output int lat);
    wait_ready();
    cap_base       = cap_d.size();
    rise_base      = rise_total;
    cmd_valid_i    = 1'b1;
    cmd_write_i    = v.wr;
    cmd_phy_addr_i = v.phy;
    cmd_reg_addr_i = v.rg;
    cmd_wdata_i    = v.wdata;
    no_pre         = np;
    @(posedge clk_i); #1;
    cmd_valid_i    = 1'b0;
    cmd_write_i    = ~v.wr;
    cmd_phy_addr_i = ~v.phy;
    cmd_reg_addr_i = ~v.rg;
    cmd_wdata_i    = ~v.wdata;
    no_pre         = ~np;
    chk("accept_ready_busy", {30'd0, cmd_ready_o, busy_o}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!rsp_valid_o && lat < 3000);
  endtask

  task automatic check_stream(input string tag, input vec_t v, input int npre);
    int n;
    int pre_bad;
    logic [31:0] act_frame;
    logic [31:0] act_oe;
    n = cap_d.size() - cap_base;
    chk({tag, "_nbits"}, 32'(n), 32'(npre + 33));
    if (n == npre + 33) begin
      pre_bad = 0;
      for (int i = 0; i < npre; i++)
        if (cap_d[cap_base + i] !== 1'b1 || cap_oe[cap_base + i] !== 1'b1) pre_bad++;
      for (int i = 0; i < 32; i++) begin
        act_frame[31 - i] = cap_d[cap_base + npre + i];
        act_oe[31 - i]    = cap_oe[cap_base + npre + i];
      end
      chk({tag, "_preamble_bad"}, 32'(pre_bad), 32'd0);
      chk({tag, "_frame"}, act_frame & v.exp_oe, v.exp_frame & v.exp_oe);
      chk({tag, "_oe"}, act_oe, v.exp_oe);
      chk({tag, "_idle_oe"}, {31'd0, cap_oe[cap_base + npre + 32]}, 32'd0);
    end
  endtask

  task automatic check_pulse_end(input string tag, input logic [15:0] rdata, input logic err);
    @(posedge clk_i); #1;
    chk({tag, "_pulse_end"}, {30'd0, rsp_valid_o, cmd_ready_o}, 32'd1);
    chk({tag, "_held"}, {15'd0, rsp_err_o, rsp_rdata_o}, {15'd0, err, rdata});
  endtask

  initial begin : main
    int lat;
    int cnt;
    int guard;
    vec_t vs;

    //        wr    phy    reg    wdata     drv   pdata     exp_frame     exp_oe        rdata     err   lat
    vecs[0] = '{1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 32'h50821140, 32'hFFFFFFFF, 16'h0000, 1'b0, 520};
    vecs[1] = '{1'b0, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h0141, 32'h60880000, 32'hFFFC0000, 16'h0141, 1'b0, 520};
    vecs[2] = '{1'b0, 5'h03, 5'h01, 16'h0000, 1'b0, 16'h0000, 32'h61840000, 32'hFFFC0000, 16'hFFFF, 1'b1, 520};
    vecs[3] = '{1'b1, 5'h1F, 5'h1F, 16'hA5C3, 1'b0, 16'h0000, 32'h5FFEA5C3, 32'hFFFFFFFF, 16'h0000, 1'b0, 520};
    vecs[4] = '{1'b0, 5'h00, 5'h1F, 16'h0000, 1'b1, 16'h8001, 32'h607C0000, 32'hFFFC0000, 16'h8001, 1'b0, 520};

    reset_n_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_phy_addr_i = '0; cmd_reg_addr_i = '0;
    cmd_wdata_i = '0; no_pre = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rdata_err", {15'd0, rsp_err_o, rsp_rdata_o}, 32'd0);
    chk("rst_mdio", {29'd0, mdc_o, mdio_o, mdio_oe_o}, 32'b010);

    @(negedge clk_i) reset_n_i = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (mdc_o || busy_o) cnt++;
    end
    chk("idle_quiet", 32'(cnt), 32'd0);

    for (int i = 0; i < 5; i++) begin
      phy_drive = vecs[i].drive;
      phy_data  = vecs[i].pdata;
      do_txn(vecs[i], 1'b0, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), {16'd0, rsp_rdata_o}, {16'd0, vecs[i].exp_rdata});
      chk($sformatf("v%0d_err", i), {31'd0, rsp_err_o}, {31'd0, vecs[i].exp_err});
      check_stream($sformatf("v%0d", i), vecs[i], int'(PRE_LEN));
      check_pulse_end($sformatf("v%0d", i), vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // Back-to-back writes with cmd_valid_i held, then a stray mid-frame valid pulse.
    phy_drive = 1'b0;
    wait_ready();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_phy_addr_i = 5'h02; cmd_reg_addr_i = 5'h04;
    cmd_wdata_i = 16'h0DE1;
    @(posedge clk_i); #1;
    chk("b2b_acc1", {31'd0, cmd_ready_o}, 32'd0);
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
    end while (!rsp_valid_o && lat < 3000);
    chk("b2b_lat1", 32'(lat), 32'd520);
    chk("b2b_not_ready_at_rsp", {31'd0, cmd_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    chk("b2b_ready_gap", {30'd0, rsp_valid_o, cmd_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("b2b_acc2", {31'd0, cmd_ready_o}, 32'd0);
    cmd_valid_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk_i); #1;
      lat++;
      cmd_valid_i = (lat == 100);
    end while (!rsp_valid_o && lat < 3000);
    cmd_valid_i = 1'b0;
    chk("b2b_lat2", 32'(lat), 32'd520);
    cnt = 0;
    repeat (600) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o || !cmd_ready_o || mdc_o) cnt++;
    end
    chk("b2b_no_extra_frame", 32'(cnt), 32'd0);

    // Reset during bit 40 of a write.
    wait_ready();
    rise_base = rise_total;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_phy_addr_i = 5'h01; cmd_reg_addr_i = 5'h00;
    cmd_wdata_i = 16'h1140;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    guard = 0;
    while ((rise_total - rise_base) < 41 && guard < 3000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    chk("rst_mid_pre_mdc_oe", {30'd0, mdc_o, mdio_oe_o}, 32'b11);
    #2 reset_n_i = 1'b0;
    #1;
    chk("rst_mid_mdc_oe", {30'd0, mdc_o, mdio_oe_o}, 32'd0);
    chk("rst_mid_ready_busy", {30'd0, cmd_ready_o, busy_o}, 32'b10);
    cnt = 0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o) cnt++;
    end
    chk("rst_mid_no_rsp", 32'(cnt), 32'd0);
    @(negedge clk_i) reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    phy_drive = vecs[1].drive;
    phy_data  = vecs[1].pdata;
    do_txn(vecs[1], 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd520);
    chk("post_rst_rdata_err", {15'd0, rsp_err_o, rsp_rdata_o}, {15'd0, 1'b0, 16'h0141});
    check_stream("post_rst", vecs[1], int'(PRE_LEN));

`ifdef MDIO_PRE_SUPPRESS_EN
    phy_drive = 1'b0;
    vs = vecs[0];
    do_txn(vs, 1'b1, lat);
    chk("nopre_latency", 32'(lat), 32'd264);
    chk("nopre_rdata_err", {15'd0, rsp_err_o, rsp_rdata_o}, 32'd0);
    if (cap_d.size() - cap_base >= 2)
      chk("nopre_first2", {30'd0, cap_d[cap_base], cap_d[cap_base + 1]}, 32'b01);
    check_stream("nopre", vs, 0);
    check_pulse_end("nopre", 16'h0000, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause 22 MDIO management master that configures the GigE front-end PHYs after the strap-based phy_init sequence releases them.
- Replaces the tied-off MDC and tristated MIO on each PHY. One instance is used per PHY.
- Takes single register read/write commands over a valid/ready handshake, serialises the frame on mdc_o/mdio_o, and returns read data with a one-cycle response pulse.
- The top level builds the MIO tristate from mdio_o/mdio_oe_o/mdio_i.

Parameters:
- CLK_DIV, 20: clk_i cycles per MDC half-period. Minimum 2. Default gives 50 MHz / 40 = 1.25 MHz MDC.
- PRE_LEN, 32: number of preamble '1' bits. Range 1..63.

Ports:
- clk_i  in  1  system clock (clk_50 domain)
- reset_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  block idle, can accept a command
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_phy_addr_i  in  5  PHYAD
- cmd_reg_addr_i  in  5  REGAD
- cmd_wdata_i  in  16  write data
- rsp_valid_o  out  1  one-cycle pulse, transaction complete
- rsp_rdata_o  out  16  read data, held until next accept
- rsp_err_o  out  1  read turnaround error, held until next accept
- busy_o  out  1  frame in progress
- mdc_o  out  1  MDC
- mdio_o  out  1  MDIO output value
- mdio_oe_o  out  1  MDIO output enable
- mdio_i  in  1  MDIO pin input

Behaviour:
- Reset (async assert, sync use after deassert): state IDLE, cmd_ready_o=1, busy_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mdc_o=0, mdio_o=1, mdio_oe_o=0, divider=0.
- Reset asserted mid-frame aborts immediately: no response pulse, bus released, MDC low.
- Handshake:
  - Accept on cmd_valid_i & cmd_ready_o. All cmd_* fields are latched at accept.
  - cmd_ready_o drops the cycle after accept and stays low until the cycle after rsp_valid_o.
  - busy_o = !cmd_ready_o.
  - cmd_valid_i while not ready is ignored; it is not queued.
- Bit timing:
  - Divider restarts at accept.
  - Each bit is CLK_DIV cycles MDC low followed by CLK_DIV cycles MDC high.
  - mdio_o/mdio_oe_o update on the cycle MDC goes low.
  - mdio_i is registered on the cycle MDC goes high.
  - MDC idles low and does not toggle in IDLE.
- Frame, MSB first, states in order:
  - PRE: PRE_LEN bits of 1, driven.
  - ST: 01, driven.
  - OP: 01 for write, 10 for read, driven.
  - PHYAD: 5 bits, driven.
  - REGAD: 5 bits, driven.
  - TA:
    - Write: 10, driven.
    - Read: oe=0 for both bits. The sample in the second TA bit must be 0, else rsp_err_o=1.
  - DATA: 16 bits.
    - Write: cmd_wdata_i driven.
    - Read: oe=0, samples shift into rsp_rdata_o MSB first.
  - IDLE_BIT: one bit period, oe=0, MDC toggles once.
  - DONE: rsp_valid_o pulses one cycle, then return to IDLE.
- Latency: total bits = PRE_LEN + 33. rsp_valid_o asserts exactly (PRE_LEN+33)*2*CLK_DIV cycles after the accept edge.
- Error reads: a read with TA error still completes all 16 data bits and returns the sampled data alongside rsp_err_o=1.
- Write responses: rsp_err_o=0 and rsp_rdata_o=0.
- Bit counter:
  - Counts 0..PRE_LEN+32 and must not wrap within a frame.
  - Divider counts 0..CLK_DIV-1 and wraps, toggling MDC.
- Simultaneous events: a cmd_valid_i in the same cycle as rsp_valid_o is not accepted (ready is still 0). It is accepted the next cycle if still asserted.

Optional Feature:
- Macro: MDIO_PRE_SUPPRESS_EN.
- When defined:
  - Adds input port cmd_no_pre_i (1 bit), latched at accept.
  - If 1, the PRE state is skipped and the frame starts at ST.
  - Total bits = 33; latency = 33*2*CLK_DIV cycles.
  - This supports PHYs that accept preamble suppression after the first frame.
- When undefined: the port is absent and every frame carries PRE_LEN preamble bits.

Test Plan (bench uses CLK_DIV=4, PRE_LEN=32):
- Write PHY=0x01, REG=0x00, data=0x1140 -> MDC-rising samples show 32x'1', then 01 01 00001 00000 10 0001000101000000, then oe=0. rsp_valid_o pulses at cycle 520 after accept, rsp_err_o=0.
- Read PHY=0x01, REG=0x02, model drives TA2=0 and data 0x0141 -> OP=10, oe=0 from TA onward, rsp_rdata_o=0x0141, rsp_err_o=0, pulse at cycle 520.
- Read with the model not driving (pull-up, mdio_i=1) -> rsp_rdata_o=0xFFFF, rsp_err_o=1.
- Back-to-back: cmd_valid_i held high across two writes -> second accept occurs exactly one cycle after the first rsp_valid_o; a cmd_valid_i pulse mid-frame is ignored (no extra frame).
- reset_n_i low at bit 40 of a write -> same cycle: mdc_o=0, mdio_oe_o=0, cmd_ready_o=1, no rsp_valid_o. After release, a new read completes normally.
- With MDIO_PRE_SUPPRESS_EN and cmd_no_pre_i=1 -> the first sampled bits are 01, and rsp_valid_o arrives at cycle 264.
